// File: rtl/fir_sm_collector.sv
`default_nettype none
// ============================================================================
// Module   : fir_sm_collector
// Purpose  : Downstream stage of the FIR core. Accepts the FIR output
//            AXI-Stream (sm_*), writes each accepted sample into an output
//            bram32 port (y_*), counts beats against a programmed length,
//            checks sm_tlast placement and keeps a wrap-around checksum.
// Ports    : axis_clk/axis_rst    clock, synchronous active-high reset
//            start/len/base       frame start pulse, beat count, byte base
//            hold                 throttle, forces sm_tready low
//            sm_tvalid/tdata/tlast/tready   FIR output stream
//            y_WE/y_EN/y_Di/y_A   output BRAM write port (registered)
//            busy/done/count/checksum/err_tlast   status to host
//            min_val/max_val      signed extremes (only with
//                                 COLLECTOR_MINMAX_EN defined)
// Options  : `define COLLECTOR_MINMAX_EN to add min_val/max_val tracking.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sm_collector #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   start,
   input  logic [31:0]            len,
   input  logic [pADDR_WIDTH-1:0] base,
   input  logic                   hold,
   input  logic                   sm_tvalid,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   input  logic                   sm_tlast,
   output logic                   sm_tready,
   output logic [3:0]             y_WE,
   output logic                   y_EN,
   output logic [pDATA_WIDTH-1:0] y_Di,
   output logic [pADDR_WIDTH-1:0] y_A,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            count,
   output logic [pDATA_WIDTH-1:0] checksum,
`ifdef COLLECTOR_MINMAX_EN
   output logic [pDATA_WIDTH-1:0] min_val,
   output logic [pDATA_WIDTH-1:0] max_val,
`endif
   output logic                   err_tlast
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state_q;
   logic [31:0]              len_q;
   logic [31:0]              count_q;
   logic [pADDR_WIDTH-1:0]   base_q;
   logic [pADDR_WIDTH-1:0]   y_a_q;
   logic [pDATA_WIDTH-1:0]   y_di_q;
   logic [pDATA_WIDTH-1:0]   checksum_q;
   logic                     y_en_q;
   logic                     done_q;
   logic                     err_q;

   logic                     accept_d;
   logic                     is_last_d;
   logic [pADDR_WIDTH-1:0]   addr_d;
   logic [pDATA_WIDTH-1:0]   checksum_d;

   // Ready depends only on registered state and the throttle, never on valid.
   assign sm_tready  = (state_q == S_RUN) && !hold;
   assign busy       = (state_q == S_RUN);
   assign accept_d   = sm_tvalid && sm_tready;
   // count_q never exceeds len_q-1 while in RUN, so equality marks the final beat.
   assign is_last_d  = (count_q == (len_q - 32'd1));
   // Word index scaled to a byte address; the sum wraps at pADDR_WIDTH bits.
   assign addr_d     = base_q + {count_q[pADDR_WIDTH-3:0], 2'b00};
   assign checksum_d = checksum_q + sm_tdata;

`ifdef COLLECTOR_MINMAX_EN
   logic [pDATA_WIDTH-1:0] min_q;
   logic [pDATA_WIDTH-1:0] max_q;
   localparam logic [pDATA_WIDTH-1:0] SMAX = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
   localparam logic [pDATA_WIDTH-1:0] SMIN = {1'b1, {(pDATA_WIDTH-1){1'b0}}};
`endif

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         count_q    <= '0;
         base_q     <= '0;
         y_a_q      <= '0;
         y_di_q     <= '0;
         checksum_q <= '0;
         y_en_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef COLLECTOR_MINMAX_EN
         min_q      <= '0;
         max_q      <= '0;
`endif
      end else begin
         // BRAM enable is a single-cycle pulse per accepted beat.
         y_en_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_q      <= len;
                  base_q     <= base;
                  count_q    <= '0;
                  checksum_q <= '0;
                  err_q      <= 1'b0;
`ifdef COLLECTOR_MINMAX_EN
                  min_q      <= SMAX;
                  max_q      <= SMIN;
`endif
                  if (len == 32'd0) begin
                     // Empty frame completes immediately without touching BRAM.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     done_q  <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (accept_d) begin
                  y_en_q     <= 1'b1;
                  y_a_q      <= addr_d;
                  y_di_q     <= sm_tdata;
                  count_q    <= count_q + 32'd1;
                  checksum_q <= checksum_d;
`ifdef COLLECTOR_MINMAX_EN
                  if ($signed(sm_tdata) < $signed(min_q)) min_q <= sm_tdata;
                  if ($signed(sm_tdata) > $signed(max_q)) max_q <= sm_tdata;
`endif
                  if (is_last_d || sm_tlast) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     // tlast must coincide exactly with the final beat.
                     err_q   <= err_q | (is_last_d ^ sm_tlast);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y_EN      = y_en_q;
   assign y_WE      = {4{y_en_q}};
   assign y_Di      = y_di_q;
   assign y_A       = y_a_q;
   assign done      = done_q;
   assign count     = count_q;
   assign checksum  = checksum_q;
   assign err_tlast = err_q;
`ifdef COLLECTOR_MINMAX_EN
   assign min_val   = min_q;
   assign max_val   = max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_sm_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sm_collector
// Purpose  : Self-checking bench for fir_sm_collector. A cycle table covers
//            the basic frame; frame-level sequences cover throttle, early and
//            missing tlast, zero length, address wrap and mid-frame reset;
//            random frames are checked against a frame-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_sm_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] len;
   logic [11:0] base;
   logic        hold;
   logic        valid;
   logic [31:0] data;
   logic        last;
   wire         ready;
   wire  [3:0]  y_WE;
   wire         y_EN;
   wire  [31:0] y_Di;
   wire  [11:0] y_A;
   wire         busy;
   wire         done;
   wire  [31:0] count;
   wire  [31:0] checksum;
   wire         err_tlast;
`ifdef COLLECTOR_MINMAX_EN
   wire  [31:0] min_val;
   wire  [31:0] max_val;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] q_data[$];
   bit          q_last[$];

   fir_sm_collector #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
      .axis_clk  (clk),
      .axis_rst  (rst),
      .start     (start),
      .len       (len),
      .base      (base),
      .hold      (hold),
      .sm_tvalid (valid),
      .sm_tdata  (data),
      .sm_tlast  (last),
      .sm_tready (ready),
      .y_WE      (y_WE),
      .y_EN      (y_EN),
      .y_Di      (y_Di),
      .y_A       (y_A),
      .busy      (busy),
      .done      (done),
      .count     (count),
      .checksum  (checksum),
`ifdef COLLECTOR_MINMAX_EN
      .min_val   (min_val),
      .max_val   (max_val),
`endif
      .err_tlast (err_tlast)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, start;
      logic [31:0] len;
      logic [11:0] base;
      logic        hold, valid;
      logic [31:0] data;
      logic        last;
      logic        en;
      logic [11:0] a;
      logic [31:0] di;
      logic        done;
      logic [31:0] cnt, cs;
      logic        err, rdy;
   } vec_t;

   function automatic vec_t mk(logic r, logic s, logic [31:0] l, logic h, logic v,
                               logic [31:0] d, logic t, logic en, logic [11:0] a,
                               logic [31:0] di, logic dn, logic [31:0] c,
                               logic [31:0] cs, logic e, logic rd);
      vec_t x;
      x.rst = r; x.start = s; x.len = l; x.base = 12'h000; x.hold = h; x.valid = v;
      x.data = d; x.last = t; x.en = en; x.a = a; x.di = di; x.done = dn;
      x.cnt = c; x.cs = cs; x.err = e; x.rdy = rd;
      return x;
   endfunction

   // Drive one frame; the expected result is derived from the whole-frame rule:
   // beats run up to the first tlast or the len-th beat, whichever is first.
   task automatic run_frame(input int len_v, input logic [11:0] base_v,
                            input int hold_mode, input bit rnd);
      int          n;
      int          idx;
      int          cyc;
      bit          acc;
      bit          err_e;
      logic [31:0] cs_e;
      logic [11:0] a_e;
`ifdef COLLECTOR_MINMAX_EN
      logic signed [31:0] mn;
      logic signed [31:0] mx;
      mn = 32'h7FFFFFFF;
      mx = 32'h80000000;
`endif
      n = 0;
      for (int i = 0; i < q_data.size(); i++) begin
         n = i + 1;
         if (q_last[i] || i == len_v - 1) break;
      end
      cs_e  = '0;
      for (int i = 0; i < n; i++) begin
         cs_e = cs_e + q_data[i];
`ifdef COLLECTOR_MINMAX_EN
         if ($signed(q_data[i]) < mn) mn = q_data[i];
         if ($signed(q_data[i]) > mx) mx = q_data[i];
`endif
      end
      err_e = (n != len_v) || !q_last[n-1];

      start = 1'b1; len = len_v; base = base_v; valid = 1'b0; hold = 1'b0;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_count", count, 0);
      chk("start_cs", checksum, 0);
      chk("start_err", err_tlast, 0);

      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 300) begin
         hold  = (hold_mode == 0) ? 1'b0 : (hold_mode == 1) ? cyc[0] : 1'($urandom % 2);
         valid = rnd ? ($urandom % 4 != 0) : 1'b1;
         data  = valid ? q_data[idx] : $urandom;
         last  = valid ? q_last[idx] : 1'($urandom % 2);
         start = rnd && ($urandom % 8 == 0);
         len   = 0;
         #2;
         chk("tready", ready, !hold);
         acc = valid && !hold;
         tick();
         chk("y_en", y_EN, acc);
         if (acc) begin
            a_e = base_v + 12'(idx * 4);
            chk("y_a", y_A, a_e);
            chk("y_di", y_Di, q_data[idx]);
            chk("y_we", y_WE, 4'hF);
            idx++;
         end else begin
            chk("y_we_idle", y_WE, 4'h0);
         end
         chk("done_edge", done, idx == n);
         chk("busy_run", busy, idx != n);
         cyc++;
      end
      start = 1'b0; valid = 1'b0; hold = 1'b0; last = 1'b0;
      if (cyc >= 300) chk("frame_timeout", idx, n);
      chk("end_count", count, n);
      chk("end_cs", checksum, cs_e);
      chk("end_err", err_tlast, err_e);
`ifdef COLLECTOR_MINMAX_EN
      chk("end_min", min_val, mn);
      chk("end_max", max_val, mx);
`endif
      // Extra valid beats after completion must not be taken.
      valid = 1'b1; data = 32'hDEAD_BEEF;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("post_tready", ready, 0);
         tick();
         chk("post_en", y_EN, 0);
         chk("post_count", count, n);
         chk("post_done", done, 1);
      end
      valid = 1'b0;
   endtask

   vec_t tbl[7];

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; base = '0; hold = 1'b0;
      valid = 1'b0; data = '0; last = 1'b0;

      // ---- basic frame, cycle by cycle ----
      //             rst st len h v data          t  en a      di            dn cnt cs            e  rdy
      tbl[0] = mk(1, 0, 0, 0, 0, 32'd0,         0, 0, 12'd0, 32'd0,         0, 0, 32'd0,         0, 0);
      tbl[1] = mk(0, 1, 4, 0, 0, 32'd0,         0, 0, 12'd0, 32'd0,         0, 0, 32'd0,         0, 1);
      tbl[2] = mk(0, 0, 4, 0, 1, 32'd1,         0, 1, 12'd0, 32'd1,         0, 1, 32'd1,         0, 1);
      tbl[3] = mk(0, 0, 4, 0, 1, 32'hFFFFFFFE,  0, 1, 12'd4, 32'hFFFFFFFE,  0, 2, 32'hFFFFFFFF,  0, 1);
      tbl[4] = mk(0, 0, 4, 0, 1, 32'd3,         0, 1, 12'd8, 32'd3,         0, 3, 32'd2,         0, 1);
      tbl[5] = mk(0, 0, 4, 0, 1, 32'd4,         1, 1, 12'd12, 32'd4,        1, 4, 32'd6,         0, 0);
      tbl[6] = mk(0, 0, 4, 0, 0, 32'd0,         0, 0, 12'd12, 32'd4,        1, 4, 32'd6,         0, 0);
      for (int i = 0; i < 7; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; len = tbl[i].len; base = tbl[i].base;
         hold = tbl[i].hold; valid = tbl[i].valid; data = tbl[i].data; last = tbl[i].last;
         tick();
         chk("tbl_en", y_EN, tbl[i].en);
         chk("tbl_we", y_WE, {4{tbl[i].en}});
         chk("tbl_a", y_A, tbl[i].a);
         chk("tbl_di", y_Di, tbl[i].di);
         chk("tbl_done", done, tbl[i].done);
         chk("tbl_count", count, tbl[i].cnt);
         chk("tbl_cs", checksum, tbl[i].cs);
         chk("tbl_err", err_tlast, tbl[i].err);
         chk("tbl_rdy", ready, tbl[i].rdy);
         chk("tbl_busy", busy, tbl[i].rdy);
      end
`ifdef COLLECTOR_MINMAX_EN
      chk("basic_min", min_val, 32'hFFFFFFFE);
      chk("basic_max", max_val, 32'd4);
`endif
      rst = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;

      // ---- throttle: hold toggles every cycle ----
      q_data = '{32'd1, 32'hFFFFFFFE, 32'd3, 32'd4};
      q_last = '{0, 0, 0, 1};
      run_frame(4, 12'h000, 1, 0);
      chk("thr_cs", checksum, 32'd6);

      // ---- early tlast ----
      q_data = '{32'd5, 32'd7, 32'd9, 32'd11};
      q_last = '{0, 1, 0, 0};
      run_frame(4, 12'h040, 0, 0);
      chk("early_count", count, 2);
      chk("early_cs", checksum, 32'd12);
      chk("early_err", err_tlast, 1);

      // ---- missing tlast with checksum wrap ----
      q_data = '{32'h7FFFFFFF, 32'd1, 32'd0};
      q_last = '{0, 0, 0};
      run_frame(3, 12'h100, 0, 0);
      chk("miss_cs", checksum, 32'h80000000);
      chk("miss_err", err_tlast, 1);

      // ---- zero length ----
      start = 1'b1; len = 0; base = 12'h055;
      tick();
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_count", count, 0);
      chk("zero_cs", checksum, 0);
      chk("zero_err", err_tlast, 0);
      valid = 1'b1; data = 32'd77;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("zero_en", y_EN, 0);
         chk("zero_done_hold", done, 1);
      end
      valid = 1'b0;

      // ---- address wrap ----
      q_data = '{32'hA5A5A5A5, 32'h0000BEEF};
      q_last = '{0, 1};
      run_frame(2, 12'hFFC, 0, 0);

      // ---- reset mid-frame ----
      start = 1'b1; len = 4; base = 12'h020;
      tick();
      start = 1'b0; valid = 1'b1;
      data = 32'd11; tick();
      chk("rst_pre_en0", y_EN, 1);
      data = 32'd22; tick();
      chk("rst_pre_a", y_A, 12'h024);
      rst = 1'b1; data = 32'd33;
      tick();
      chk("rst_en", y_EN, 0);
      chk("rst_we", y_WE, 0);
      chk("rst_a", y_A, 0);
      chk("rst_di", y_Di, 0);
      chk("rst_count", count, 0);
      chk("rst_cs", checksum, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy", ready, 0);
`ifdef COLLECTOR_MINMAX_EN
      chk("rst_min", min_val, 0);
      chk("rst_max", max_val, 0);
`endif
      rst = 1'b0; valid = 1'b0;
      tick();
      chk("rst_idle_en", y_EN, 0);
      chk("rst_idle_rdy", ready, 0);
      q_data = '{32'd9};
      q_last = '{1};
      run_frame(1, 12'h100, 0, 0);
      chk("rst_new_count", count, 1);
      chk("rst_new_done", done, 1);

      // ---- random frames ----
      for (int f = 0; f < 25; f++) begin
         int l;
         l = 1 + int'($urandom % 8);
         q_data.delete();
         q_last.delete();
         for (int i = 0; i < l; i++) begin
            q_data.push_back($urandom);
            q_last.push_back((i == l - 1) ? ($urandom % 2 == 0) : ($urandom % 6 == 0));
         end
         run_frame(l, 12'($urandom), 2, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_sm_collector.md
Name: fir_sm_collector

Overview:
Downstream stage of the fir core. Consumes the FIR output AXI-Stream (sm_*) and writes each accepted sample into an output bram32 (y_* port). It counts beats against a programmed length, checks sm_tlast placement, and keeps a running 32-bit checksum. It signals done to the host/config layer when the frame completes.

Parameters:
pADDR_WIDTH, 12, byte-address width of output BRAM port
pDATA_WIDTH, 32, sample/data width

Ports:
axis_clk  input  1  clock
axis_rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a frame (ignored unless IDLE or DONE)
len  input  32  expected beat count, latched on accepted start
base  input  pADDR_WIDTH  BRAM byte base address, latched on accepted start
hold  input  1  throttle; forces sm_tready low while 1
sm_tvalid  input  1  FIR output valid
sm_tdata  input  pDATA_WIDTH  FIR output sample (signed)
sm_tlast  input  1  FIR output last
sm_tready  output  1  collector ready
y_WE  output  4  BRAM byte write enables
y_EN  output  1  BRAM enable
y_Di  output  pDATA_WIDTH  BRAM write data
y_A  output  pADDR_WIDTH  BRAM byte address
busy  output  1  state==RUN
done  output  1  frame complete (sticky until next start or reset)
count  output  32  beats accepted this frame
checksum  output  pDATA_WIDTH  wrap-around sum of accepted samples
err_tlast  output  1  sticky tlast-placement error for this frame

Behaviour:
- One clock domain (axis_clk). Reset is synchronous and active-high (axis_rst). Every output is registered except sm_tready and busy, which decode the registered state.
- Reset values: state IDLE; sm_tready 0, busy 0, done 0, y_EN 0, y_WE 0, y_A 0, y_Di 0, count 0, checksum 0, err_tlast 0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start, len!=0: latch len/base; clear count, checksum, err_tlast, done; go to RUN.
  - IDLE/DONE + start, len==0: clear as above; go to DONE; done=1 the next cycle; no BRAM access.
  - RUN: start is ignored.
- sm_tready = (state==RUN) && !hold.
- A beat is accepted when sm_tvalid && sm_tready. No acceptance occurs outside RUN.
- On each accepted beat, on the next cycle for exactly one cycle: y_EN=1, y_WE=4'hF, y_Di=sm_tdata, y_A=base+(count<<2), truncated to pADDR_WIDTH. The address wraps modulo 2^pADDR_WIDTH.
- On each accepted beat, in the same edge: count+=1; checksum+=sm_tdata, modulo 2^pDATA_WIDTH.
- All other cycles: y_EN=0, y_WE=0. y_A and y_Di hold their last value.
- Completion is evaluated on the accepted beat; idx = count before increment.
  - idx==len-1 && sm_tlast: go to DONE, err_tlast unchanged.
  - idx==len-1 && !sm_tlast: go to DONE, err_tlast=1 (missing tlast).
  - idx<len-1 && sm_tlast: go to DONE early, err_tlast=1.
- done rises on the same edge as the final y_EN pulse. In DONE, sm_tready=0. done, count and checksum hold until the next start.
- Reset mid-frame: all outputs return to reset values on that edge. A pending BRAM write is dropped, so y_EN=0.
- No combinational path from sm_tvalid to sm_tready.

Optional Feature:
COLLECTOR_MINMAX_EN
- Defined: adds outputs min_val and max_val (pDATA_WIDTH, signed, registered).
  - An accepted start sets min_val=0x7FFFFFFF and max_val=0x80000000.
  - Each accepted beat updates both with signed compare, on the same edge as checksum.
  - Both reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: start, len=4, base=0, samples 1,-2,3,4 with tlast on the 4th, hold=0 → writes A=0,4,8,12 with those data; count=4, checksum=6, err_tlast=0; done=1 with the last write. With COLLECTOR_MINMAX_EN: min=-2, max=4.
- Throttle: same frame, hold toggling every cycle, sm_tvalid held high → no y_EN on a hold=1 cycle (the following cycle); identical writes, checksum=6, done=1.
- Early tlast: len=4, tlast on 2nd beat (values 5,7) → DONE after 2 beats; count=2, checksum=12, err_tlast=1; no further writes; sm_tready=0.
- Missing tlast: len=3, tlast never set, samples 0x7FFFFFFF,1,0 → DONE after 3 beats; checksum=0x80000000 (wrap), err_tlast=1.
- Zero length / address wrap: start with len=0 → done=1 next cycle, y_EN never asserted. Then start with base=0xFFC, len=2 → writes at A=0xFFC and 0x000.
- Reset mid-frame: len=4, axis_rst after 2 beats → next cycle all outputs are at reset values, sm_tready=0. A new start with len=1, sample 9, tlast → write at A=base, count=1, done=1.
